// File: rtl/sap1_pkg.sv
// sap1_pkg
//   Shared definitions for the SAP-1 control path:
//   - the opcode enumeration,
//   - the bit positions of the 12-bit control word,
//   - the fixed fetch and execute control words.
//   Control-word layout, MSB first:
//   {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar}
package sap1_pkg;

  localparam int NUM_T_STATES = 6;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  // Control-word bit positions
  localparam int CW_CP    = 11;
  localparam int CW_EP    = 10;
  localparam int CW_LM_N  = 9;
  localparam int CW_CE_N  = 8;
  localparam int CW_LI_N  = 7;
  localparam int CW_EI_N  = 6;
  localparam int CW_LA_N  = 5;
  localparam int CW_EA    = 4;
  localparam int CW_SU    = 3;
  localparam int CW_EU    = 2;
  localparam int CW_LB_N  = 1;
  localparam int CW_LO_N  = 0;

  // Idle word: every active-low load/enable deasserted, everything else low (0x3E3)
  localparam logic [11:0] CW_NOP = 12'((1 << CW_LM_N) | (1 << CW_CE_N) | (1 << CW_LI_N) |
                                       (1 << CW_EI_N) | (1 << CW_LA_N) | (1 << CW_LB_N) |
                                       (1 << CW_LO_N));

  // Fetch words, identical for every opcode
  localparam logic [11:0] CW_T1 = (CW_NOP | 12'(1 << CW_EP)) & ~12'(1 << CW_LM_N);   // 0x5E3
  localparam logic [11:0] CW_T2 =  CW_NOP | 12'(1 << CW_CP);                          // 0xBE3
  localparam logic [11:0] CW_T3 =  CW_NOP & ~12'((1 << CW_CE_N) | (1 << CW_LI_N));    // 0x263

  // Execute words
  localparam logic [11:0] CW_IR_TO_MAR = CW_NOP & ~12'((1 << CW_LM_N) | (1 << CW_EI_N)); // 0x1A3
  localparam logic [11:0] CW_RAM_TO_A  = CW_NOP & ~12'((1 << CW_CE_N) | (1 << CW_LA_N)); // 0x2C3
  localparam logic [11:0] CW_RAM_TO_B  = CW_NOP & ~12'((1 << CW_CE_N) | (1 << CW_LB_N)); // 0x2E1
  localparam logic [11:0] CW_ALU_TO_A  = (CW_NOP & ~12'(1 << CW_LA_N)) | 12'(1 << CW_EU); // 0x3C7
  localparam logic [11:0] CW_DIFF_TO_A = CW_ALU_TO_A | 12'(1 << CW_SU);                  // 0x3CF
  localparam logic [11:0] CW_A_TO_OUT  = (CW_NOP | 12'(1 << CW_EA)) & ~12'(1 << CW_LO_N); // 0x3F2

  // True for the five opcodes the micro-program implements
  function automatic logic isDefinedOp(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap1_cw_decode.sv
// sap1_cw_decode
//   Purely combinational micro-op table: (T-state, opcode) -> control word.
//   No gating for halt/fault here so the table can be reused by a microcoded
//   sequencer.
//   Ports:
//     i_state  [5:0]  one-hot T-state (bit 0 = T1)
//     i_opcode [3:0]  instruction-register opcode nibble
//     o_cw     [11:0] control word; NOP for any state pattern not in the table
module sap1_cw_decode
  import sap1_pkg::*;
(
  input  logic [NUM_T_STATES-1:0] i_state,
  input  logic [3:0]              i_opcode,
  output logic [11:0]             o_cw
);

  always_comb begin
    o_cw = CW_NOP;
    case (i_state)
      6'b000001: o_cw = CW_T1;
      6'b000010: o_cw = CW_T2;
      6'b000100: o_cw = CW_T3;
      6'b001000: begin
        case (opcode_e'(i_opcode))
          OP_LDA, OP_ADD, OP_SUB: o_cw = CW_IR_TO_MAR;
          OP_OUT:                 o_cw = CW_A_TO_OUT;
          default:                o_cw = CW_NOP;
        endcase
      end
      6'b010000: begin
        case (opcode_e'(i_opcode))
          OP_LDA:         o_cw = CW_RAM_TO_A;
          OP_ADD, OP_SUB: o_cw = CW_RAM_TO_B;
          default:        o_cw = CW_NOP;
        endcase
      end
      6'b100000: begin
        case (opcode_e'(i_opcode))
          OP_ADD:  o_cw = CW_ALU_TO_A;
          OP_SUB:  o_cw = CW_DIFF_TO_A;
          default: o_cw = CW_NOP;
        endcase
      end
      default: o_cw = CW_NOP;
    endcase
  end

endmodule

// File: rtl/sap1_control_sequencer.sv
// sap1_control_sequencer
//   Consumer end of the SAP-1 T-state interface. Decodes the control word from
//   the ring-counter T-state and opcode, checks the T-state sequence, latches
//   halt / fault / bad-opcode flags and counts retired instructions.
//   All registers update on the falling edge so the control word is settled
//   before the rising edge where datapath registers load.
//   Ports:
//     CLK        clock, registers update on negedge
//     CLR_bar    asynchronous active-low clear
//     state      one-hot T-state from ring counter (all-zero = pre-T1)
//     opcode     upper nibble of the instruction register
//     con        12-bit control word
//     hlt        halt request to the clock block
//     seq_fault  sticky illegal-sequence flag
//     bad_op     sticky undefined-opcode flag
//     retired    completed-instruction counter (wraps)
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter int STATES   = 6,
  parameter int RETIRE_W = 8
) (
  input  logic                CLK,
  input  logic                CLR_bar,
  input  logic [STATES-1:0]   state,
  input  logic [3:0]          opcode,
  output logic [11:0]         con,
  output logic                hlt,
  output logic                seq_fault,
  output logic                bad_op,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [STATES-1:0] T1 = STATES'(1);
  localparam logic [STATES-1:0] T4 = STATES'(8);
  localparam logic [STATES-1:0] T6 = {1'b1, {(STATES-1){1'b0}}};

  logic                r_halted;
  logic                r_seqFault;
  logic                r_badOp;
  logic [RETIRE_W-1:0] r_retired;
  logic [STATES-1:0]   r_prevState;

  logic [11:0]         w_decodedCw;
  logic [STATES-1:0]   w_expectedNext;
  logic                w_legal;
  logic                w_faultNext;
  logic                w_atT4;

  sap1_cw_decode u_decode (
    .i_state  (state),
    .i_opcode (opcode),
    .o_cw     (w_decodedCw)
  );

  // The only legal successor of a one-hot state is its left rotation (T6 wraps
  // to T1). Leaving clear, the counter may idle at zero and then enter T1.
  assign w_expectedNext = {r_prevState[STATES-2:0], r_prevState[STATES-1]};
  assign w_legal = ((state == '0) && (r_prevState == '0)) ||
                   ((state == T1) && (r_prevState == '0)) ||
                   ($onehot(state) && (state == w_expectedNext));

  // A fault detected on this edge already blocks halt and retire on the same edge
  assign w_faultNext = r_seqFault | ~w_legal;
  assign w_atT4      = (state == T4);

  // Pre-T1, halted or faulted: hold the datapath idle
  always_comb begin
    con = w_decodedCw;
    if ((state == '0) || r_halted || r_seqFault) begin
      con = CW_NOP;
    end
  end

  always_ff @(negedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      r_halted    <= 1'b0;
      r_seqFault  <= 1'b0;
      r_badOp     <= 1'b0;
      r_retired   <= '0;
      r_prevState <= '0;
    end else begin
      r_prevState <= state;
      r_seqFault  <= w_faultNext;
      if (w_atT4 && (opcode == OP_HLT) && !w_faultNext) begin
        r_halted <= 1'b1;
      end
      if (w_atT4 && !isDefinedOp(opcode)) begin
        r_badOp <= 1'b1;
      end
      if ((state == T6) && !r_halted && !w_faultNext) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end
    end
  end

  assign hlt       = r_halted;
  assign seq_fault = r_seqFault;
  assign bad_op    = r_badOp;
  assign retired   = r_retired;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// tb_sap1_control_sequencer
//   Scoreboard bench for the SAP-1 control sequencer. A behavioural model
//   predicts the control word and flags for each T-state driven; the expected
//   entry is queued when the stimulus is applied and compared when the DUT
//   output is sampled.
module tb_sap1_control_sequencer;

  localparam int RetireW = 4;

  logic               CLK = 1'b0;
  logic               CLR_bar = 1'b0;
  logic [5:0]         state = 6'b0;
  logic [3:0]         opcode = 4'b0;
  logic [11:0]        con;
  logic               hlt;
  logic               seqFault;
  logic               badOp;
  logic [RetireW-1:0] retired;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state
  logic               mHalted = 1'b0;
  logic               mFault = 1'b0;
  logic               mBad = 1'b0;
  logic [RetireW-1:0] mRetired = '0;
  logic [5:0]         mPrev = 6'b0;

  typedef struct {
    string              tag;
    logic [11:0]        con;
    logic               hlt;
    logic               fault;
    logic               bad;
    logic [RetireW-1:0] retired;
  } expectT;

  expectT scoreboard[$];

  sap1_control_sequencer #(
    .STATES   (6),
    .RETIRE_W (RetireW)
  ) dut (
    .CLK       (CLK),
    .CLR_bar   (CLR_bar),
    .state     (state),
    .opcode    (opcode),
    .con       (con),
    .hlt       (hlt),
    .seq_fault (seqFault),
    .bad_op    (badOp),
    .retired   (retired)
  );

  // Free-running clock, 10 time-unit period
  always #5 CLK = ~CLK;

  // Hard stop in case something ever stalls the stimulus
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Micro-op table written out literally, one entry per (T-state, opcode)
  function automatic logic [11:0] modelCw(input logic [5:0] s, input logic [3:0] op);
    logic [11:0] w;
    w = 12'h3E3;
    case (s)
      6'b000001: w = 12'h5E3;
      6'b000010: w = 12'hBE3;
      6'b000100: w = 12'h263;
      6'b001000: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = 12'h1A3;
        else if (op == 4'hE) w = 12'h3F2;
      end
      6'b010000: begin
        if (op == 4'h0) w = 12'h2C3;
        else if (op == 4'h1 || op == 4'h2) w = 12'h2E1;
      end
      6'b100000: begin
        if (op == 4'h1) w = 12'h3C7;
        else if (op == 4'h2) w = 12'h3CF;
      end
      default: w = 12'h3E3;
    endcase
    return w;
  endfunction

  function automatic bit isOneHot(input logic [5:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (s[i]) n++;
    end
    return n == 1;
  endfunction

  // Drive one T-state for one clock; predict, queue, then compare the control
  // word mid-cycle and the flags just after the sampling negedge
  task automatic applyStimulus(input string tag, input logic [5:0] s, input logic [3:0] op);
    expectT e;
    expectT got;
    logic [5:0] rot;
    logic legal;
    logic faultNext;
    state = s;
    opcode = op;
    e.tag = tag;
    e.con = (s == 6'b0 || mHalted || mFault) ? 12'h3E3 : modelCw(s, op);
    rot = {mPrev[4:0], mPrev[5]};
    legal = ((s == 6'b0 || s == 6'b000001) && mPrev == 6'b0) || (isOneHot(s) && s == rot);
    faultNext = mFault || !legal;
    if (s == 6'b001000 && op == 4'hF && !faultNext) mHalted = 1'b1;
    if (s == 6'b001000 && !(op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF})) mBad = 1'b1;
    if (s == 6'b100000 && !mHalted && !faultNext) mRetired = mRetired + 1'b1;
    mFault = faultNext;
    mPrev = s;
    e.hlt = mHalted;
    e.fault = mFault;
    e.bad = mBad;
    e.retired = mRetired;
    scoreboard.push_back(e);

    @(posedge CLK);
    #1;
    got = scoreboard.pop_front();
    checkOutput({got.tag, ".con"}, 32'(con), 32'(got.con));
    @(negedge CLK);
    #1;
    checkOutput({got.tag, ".hlt"}, 32'(hlt), 32'(got.hlt));
    checkOutput({got.tag, ".seqFault"}, 32'(seqFault), 32'(got.fault));
    checkOutput({got.tag, ".badOp"}, 32'(badOp), 32'(got.bad));
    checkOutput({got.tag, ".retired"}, 32'(retired), 32'(got.retired));
  endtask

  // Walk T1..T6 for one instruction
  task automatic runInstr(input string tag, input logic [3:0] op);
    for (int i = 0; i < 6; i++) begin
      applyStimulus($sformatf("%s.T%0d", tag, i + 1), 6'(1 << i), op);
    end
  endtask

  // Asynchronous clear, asserted mid-cycle; outputs must clear immediately
  task automatic applyReset(input string tag);
    CLR_bar = 1'b0;
    #2;
    state = 6'b0;
    opcode = 4'b0;
    mHalted = 1'b0;
    mFault = 1'b0;
    mBad = 1'b0;
    mRetired = '0;
    mPrev = 6'b0;
    #1;
    checkOutput({tag, ".con"}, 32'(con), 32'h3E3);
    checkOutput({tag, ".hlt"}, 32'(hlt), 32'h0);
    checkOutput({tag, ".seqFault"}, 32'(seqFault), 32'h0);
    checkOutput({tag, ".badOp"}, 32'(badOp), 32'h0);
    checkOutput({tag, ".retired"}, 32'(retired), 32'h0);
    CLR_bar = 1'b1;
  endtask

  // Main sequence of scenarios
  initial begin
    logic [3:0] pool [5];
    pool[0] = 4'h0; pool[1] = 4'h1; pool[2] = 4'h2; pool[3] = 4'hE; pool[4] = 4'h5;

    repeat (2) @(negedge CLK);
    #1;

    // Clean LDA after clear, including an idle zero state
    applyReset("rst0");
    applyStimulus("lda.pre", 6'b0, 4'h0);
    runInstr("lda", 4'h0);
    checkOutput("lda.retiredOne", 32'(retired), 32'd1);

    // ADD then SUB
    applyReset("rst1");
    applyStimulus("alu.pre0", 6'b0, 4'h1);
    applyStimulus("alu.pre1", 6'b0, 4'h1);
    runInstr("add", 4'h1);
    runInstr("sub", 4'h2);
    checkOutput("alu.retiredTwo", 32'(retired), 32'd2);

    // OUT then an undefined opcode: bad_op latches, execution continues
    runInstr("out", 4'hE);
    runInstr("undef", 4'h5);
    checkOutput("undef.badOp", 32'(badOp), 32'd1);
    checkOutput("undef.retired", 32'(retired), 32'd4);

    // Halt freezes retire and forces NOP until clear (mid-instruction clear)
    applyReset("rst2");
    applyStimulus("hlt.pre", 6'b0, 4'h0);
    runInstr("hlt.lda", 4'h0);
    runInstr("hlt", 4'hF);
    runInstr("hlt.after", 4'h1);
    checkOutput("hlt.held", 32'(hlt), 32'd1);
    checkOutput("hlt.frozen", 32'(retired), 32'd1);
    applyStimulus("hlt.midT1", 6'b000001, 4'h0);
    applyReset("rst3");

    // Skip T2 -> T4
    applyStimulus("skip.pre", 6'b0, 4'h0);
    runInstr("skip.lda", 4'h0);
    applyStimulus("skip.T1", 6'b000001, 4'h1);
    applyStimulus("skip.T2", 6'b000010, 4'h1);
    applyStimulus("skip.T4", 6'b001000, 4'h1);
    applyStimulus("skip.T5", 6'b010000, 4'h1);
    applyStimulus("skip.T6", 6'b100000, 4'h1);
    runInstr("skip.after", 4'h0);
    checkOutput("skip.fault", 32'(seqFault), 32'd1);
    checkOutput("skip.frozen", 32'(retired), 32'd1);

    // Non-one-hot pattern
    applyReset("rst4");
    applyStimulus("multi.pre", 6'b0, 4'h0);
    applyStimulus("multi.T1", 6'b000001, 4'h0);
    applyStimulus("multi.bad", 6'b000011, 4'h0);
    checkOutput("multi.fault", 32'(seqFault), 32'd1);

    // Return to zero mid-run; a simultaneous HLT on a faulting edge must not halt
    applyReset("rst5");
    applyStimulus("zero.pre", 6'b0, 4'h0);
    applyStimulus("zero.T1", 6'b000001, 4'h0);
    applyStimulus("zero.T2", 6'b000010, 4'h0);
    applyStimulus("zero.drop", 6'b0, 4'h0);
    checkOutput("zero.fault", 32'(seqFault), 32'd1);
    applyReset("rst6");
    applyStimulus("both.pre", 6'b0, 4'hF);
    applyStimulus("both.T1", 6'b000001, 4'hF);
    applyStimulus("both.T4", 6'b001000, 4'hF);
    checkOutput("both.noHalt", 32'(hlt), 32'd0);

    // Counter wrap: 2^RetireW instructions of mixed non-halting opcodes
    applyReset("rst7");
    applyStimulus("wrap.pre", 6'b0, 4'h0);
    for (int n = 0; n < (1 << RetireW); n++) begin
      runInstr($sformatf("wrap%0d", n), pool[$urandom_range(0, 4)]);
    end
    checkOutput("wrap.zero", 32'(retired), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sap1_control_sequencer.md
Name: sap1_control_sequencer

Overview:
- Consumer end of the SAP-1 T-state interface.
- Takes the one-hot T-state vector from the ring counter and the opcode nibble from the instruction register.
- Drives the 12-bit control word, the HLT request to the clock block, a sticky sequence-fault flag, a sticky bad-opcode flag and an instruction-retire counter.
- All state updates on the falling clock edge, the same edge the ring counter advances on, so the control word is stable at every rising edge when datapath registers load.

Parameters:
- STATES, 6, width of the incoming one-hot T-state vector (T1..T6). Must be 6 for the fixed SAP-1 micro-program.
- RETIRE_W, 8, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all registers update on negedge.
- CLR_bar  in  1  asynchronous active-low reset.
- state  in  STATES  one-hot T-state from the ring counter. All-zero means pre-T1 after clear.
- opcode  in  4  upper nibble of the instruction register.
- con  out  12  control word {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar}.
- hlt  out  1  halt request; clock block gates CLK while high.
- seq_fault  out  1  sticky: illegal T-state sequence seen.
- bad_op  out  1  sticky: undefined opcode seen at T4.
- retired  out  RETIRE_W  count of completed instruction cycles.

Behaviour:
- Reset (CLR_bar low, async): halted_q=0, seq_fault=0, bad_op=0, retired=0, prev_q=0; con=0x3E3 (NOP).
- con is combinational from (state, opcode, halted_q, seq_fault):
  - 0x3E3 if state==0, halted_q=1 or seq_fault=1; otherwise the micro-op table below.
  - T1=0x5E3 (Ep, Lm); T2=0xBE3 (Cp); T3=0x263 (CE, Li), all opcodes.
  - LDA 0000: T4=0x1A3, T5=0x2C3, T6=0x3E3.
  - ADD 0001: T4=0x1A3, T5=0x2E1, T6=0x3C7.
  - SUB 0010: T4=0x1A3, T5=0x2E1, T6=0x3CF.
  - OUT 1110: T4=0x3F2, T5=T6=0x3E3.
  - HLT 1111 and every other opcode: T4..T6=0x3E3.
- Each negedge with CLR_bar high samples state before the ring counter's update at that edge:
  - Sequence check: sampled s is legal iff (s==0 and prev_q==0) or (s==T1 and prev_q==0) or (s is one-hot and s==rotl(prev_q)). T6->T1 is the wrap. Illegal (non-one-hot, skip, 0 after non-zero) -> seq_fault<=1, held until reset. prev_q<=s.
  - Halt: s==T4, opcode==1111, no fault -> halted_q<=1. hlt = halted_q; cleared only by reset.
  - Bad op: s==T4, opcode not in {0000,0001,0010,1110,1111} -> bad_op<=1. Execution continues as NOP.
  - Retire: s==T6, halted_q==0, seq_fault==0 -> retired<=retired+1, wraps modulo 2^RETIRE_W.
- Simultaneous events (e.g. HLT and seq_fault on one edge):
  - seq_fault takes priority; halted_q does not set.
  - Once seq_fault or halted_q is set, retire stops and con stays NOP.
- Reset mid-instruction: all registers clear immediately. First edge after release samples 0 (legal); second samples T1 (legal).
- Latency: con follows state with zero cycles (combinational). Flags and counter update at the negedge where the triggering state is sampled.

Decomposition:
- sap1_pkg holds:
  - opcode enum (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - control-word bit-index constants;
  - CW_NOP=12'h3E3 and the T1..T3 fetch words.
- Sub-module sap1_cw_decode: purely combinational (state, opcode) -> con table, shared with the future microcoded variant. The sequencer adds gating and registers.

Test Plan:
- Reset, then 7 negedges of a correct ring sequence with opcode=0000 -> con = 3E3, 5E3, BE3, 263, 1A3, 2C3, 3E3; retired=1; flags 0.
- ADD then SUB, two full cycles -> T6 con = 3C7 then 3CF; T5 con = 2E1 both; retired=2.
- HLT at T4 -> hlt=1 after that negedge; con=3E3 thereafter; retired frozen; CLR_bar pulse -> hlt=0, retired=0.
- Inject state T2->T4 skip -> seq_fault=1 at sampling edge; con=3E3 forever; retired frozen until reset.
- Inject state=6'b000011 -> seq_fault=1; also state returning to 0 mid-run -> seq_fault=1.
- opcode=0101 through T4..T6 -> bad_op=1, con=3E3 at T4..T6, retired increments. With RETIRE_W=2, 4 instructions -> retired wraps to 0.
